// File: rtl/axi_join_arb_pkg.sv
// Shared types for the 2:1 AXI join arbiter: channel payloads, port request/response bundles.
package axi_join_arb_pkg;

  localparam int unsigned DefSlvIdWidth = 4;
  localparam int unsigned DefMstIdWidth = DefSlvIdWidth + 1;
  localparam int unsigned AddrWidth     = 16;
  localparam int unsigned DataWidth     = 16;
  localparam int unsigned LenWidth      = 8;

  typedef logic [0:0] idx_t;

  typedef struct packed {
    logic [DefSlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]     addr;
    logic [LenWidth-1:0]      len;
  } slv_ax_t;

  typedef struct packed {
    logic [DefMstIdWidth-1:0] id;
    logic [AddrWidth-1:0]     addr;
    logic [LenWidth-1:0]      len;
  } mst_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [DefSlvIdWidth-1:0] id;
    logic [1:0]               resp;
  } slv_b_t;

  typedef struct packed {
    logic [DefMstIdWidth-1:0] id;
    logic [1:0]               resp;
  } mst_b_t;

  typedef struct packed {
    logic [DefSlvIdWidth-1:0] id;
    logic [DataWidth-1:0]     data;
    logic [1:0]               resp;
    logic                     last;
  } slv_r_t;

  typedef struct packed {
    logic [DefMstIdWidth-1:0] id;
    logic [DataWidth-1:0]     data;
    logic [1:0]               resp;
    logic                     last;
  } mst_r_t;

  typedef struct packed {
    slv_ax_t aw;
    logic    aw_valid;
    w_chan_t w;
    logic    w_valid;
    logic    b_ready;
    slv_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_slv_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    slv_b_t b;
    logic   b_valid;
    logic   ar_ready;
    slv_r_t r;
    logic   r_valid;
  } axi_slv_resp_t;

  typedef struct packed {
    mst_ax_t aw;
    logic    aw_valid;
    w_chan_t w;
    logic    w_valid;
    logic    b_ready;
    mst_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_mst_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    mst_b_t b;
    logic   b_valid;
    logic   ar_ready;
    mst_r_t r;
    logic   r_valid;
  } axi_mst_resp_t;

endpackage

// File: rtl/axi_join_arb_rr.sv
// Two-input round-robin arbiter; the grant is held while the winner is valid but not yet accepted.
module axi_join_arb_rr
  import axi_join_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       ready_i,
  output logic       valid_o,
  output idx_t       idx_o
);

  idx_t prio_q, prio_d;
  idx_t lock_idx_q, lock_idx_d;
  logic lock_q, lock_d;

  always_comb begin
    idx_o      = prio_q;
    valid_o    = 1'b0;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    prio_d     = prio_q;
    if (lock_q) begin
      idx_o = lock_idx_q;
    end else if (!req_i[prio_q] && req_i[~prio_q]) begin
      idx_o = ~prio_q;
    end
    valid_o    = req_i[idx_o];
    lock_d     = valid_o && !ready_i;
    lock_idx_d = idx_o;
    // Priority passes to the other port only once the winner is accepted.
    if (valid_o && ready_i) begin
      prio_d = ~idx_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q     <= '0;
      lock_idx_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      lock_idx_q <= lock_idx_d;
      lock_q     <= lock_d;
    end
  end

endmodule

// File: rtl/axi_join_arb.sv
// 2:1 AXI join: round-robin AW/AR with port index prepended to ID, W steered by AW grant order,
// B/R routed back by the ID MSB.
module axi_join_arb
  import axi_join_arb_pkg::*;
#(
  parameter int unsigned SlvIdWidth = DefSlvIdWidth,
  parameter int unsigned MaxWTrans  = 8,
  parameter type slv_req_t  = axi_slv_req_t,
  parameter type slv_resp_t = axi_slv_resp_t,
  parameter type mst_req_t  = axi_mst_req_t,
  parameter type mst_resp_t = axi_mst_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  slv_req_t  slv_reqs_i  [2],
  output slv_resp_t slv_resps_o [2],
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
);

  localparam int unsigned PtrWidth = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
  localparam int unsigned CntWidth = $clog2(MaxWTrans + 1);

  if (MaxWTrans < 1) begin : gen_bad_depth
    $error("axi_join_arb: MaxWTrans must be at least 1");
  end
  if ($bits(mst_req_o.aw.id) != SlvIdWidth + 1) begin : gen_bad_id
    $error("axi_join_arb: master ID width must be SlvIdWidth+1");
  end

  logic                 post_rst_q, post_rst_d;
  logic [MaxWTrans-1:0] fifo_q, fifo_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;

  logic       out_en, w_full, w_fwd, aw_push, w_pop;
  logic       aw_valid, ar_valid;
  idx_t       aw_idx, ar_idx, w_sel, b_sel, r_sel;
  logic [1:0] aw_req, ar_req;

  // Handshakes stay off while in reset and for the cycle right after it.
  assign out_en = !(rst_i || post_rst_q);
  assign w_full = (cnt_q == CntWidth'(MaxWTrans));
  assign w_fwd  = out_en && (cnt_q != '0);
  assign w_sel  = fifo_q[rd_ptr_q];
  assign b_sel  = idx_t'(mst_resp_i.b.id[SlvIdWidth]);
  assign r_sel  = idx_t'(mst_resp_i.r.id[SlvIdWidth]);

  assign aw_req = {slv_reqs_i[1].aw_valid, slv_reqs_i[0].aw_valid} & {2{out_en && !w_full}};
  assign ar_req = {slv_reqs_i[1].ar_valid, slv_reqs_i[0].ar_valid} & {2{out_en}};

  assign aw_push = aw_valid && mst_resp_i.aw_ready;
  assign w_pop   = w_fwd && slv_reqs_i[w_sel].w_valid && mst_resp_i.w_ready
                   && slv_reqs_i[w_sel].w.last;

  axi_join_arb_rr u_aw_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (aw_req),
    .ready_i (mst_resp_i.aw_ready),
    .valid_o (aw_valid),
    .idx_o   (aw_idx)
  );

  axi_join_arb_rr u_ar_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (ar_req),
    .ready_i (mst_resp_i.ar_ready),
    .valid_o (ar_valid),
    .idx_o   (ar_idx)
  );

  // W route FIFO: one entry per granted AW whose W burst has not yet finished.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_rst_d = 1'b0;
    if (aw_push) begin
      fifo_d[wr_ptr_q] = aw_idx;
      wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxWTrans - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxWTrans - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    cnt_d = cnt_q + CntWidth'(aw_push) - CntWidth'(w_pop);
  end

  always_comb begin
    mst_req_o      = '0;
    slv_resps_o[0] = '0;
    slv_resps_o[1] = '0;

    mst_req_o.aw.id   = {aw_idx, slv_reqs_i[aw_idx].aw.id};
    mst_req_o.aw.addr = slv_reqs_i[aw_idx].aw.addr;
    mst_req_o.aw.len  = slv_reqs_i[aw_idx].aw.len;
    mst_req_o.aw_valid = aw_valid;
    slv_resps_o[aw_idx].aw_ready = aw_valid && mst_resp_i.aw_ready;

    mst_req_o.ar.id   = {ar_idx, slv_reqs_i[ar_idx].ar.id};
    mst_req_o.ar.addr = slv_reqs_i[ar_idx].ar.addr;
    mst_req_o.ar.len  = slv_reqs_i[ar_idx].ar.len;
    mst_req_o.ar_valid = ar_valid;
    slv_resps_o[ar_idx].ar_ready = ar_valid && mst_resp_i.ar_ready;

    mst_req_o.w       = slv_reqs_i[w_sel].w;
    mst_req_o.w_valid = w_fwd && slv_reqs_i[w_sel].w_valid;
    slv_resps_o[w_sel].w_ready = w_fwd && mst_resp_i.w_ready;

    // Responses: payload to both ports with the routing bit stripped, valid only to the owner.
    for (int i = 0; i < 2; i++) begin
      slv_resps_o[i].b.id   = mst_resp_i.b.id[SlvIdWidth-1:0];
      slv_resps_o[i].b.resp = mst_resp_i.b.resp;
      slv_resps_o[i].r.id   = mst_resp_i.r.id[SlvIdWidth-1:0];
      slv_resps_o[i].r.data = mst_resp_i.r.data;
      slv_resps_o[i].r.resp = mst_resp_i.r.resp;
      slv_resps_o[i].r.last = mst_resp_i.r.last;
    end
    slv_resps_o[b_sel].b_valid = out_en && mst_resp_i.b_valid;
    slv_resps_o[r_sel].r_valid = out_en && mst_resp_i.r_valid;
    mst_req_o.b_ready = slv_reqs_i[b_sel].b_ready;
    mst_req_o.r_ready = slv_reqs_i[r_sel].r_ready;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      post_rst_q <= 1'b1;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      post_rst_q <= post_rst_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_join_arb.sv
// Self-checking bench for axi_join_arb: B/R routing table, directed AW/W/AR/reset sequences,
// and randomized AW/W traffic against a queue-based reference model.
module tb_axi_join_arb;
  import axi_join_arb_pkg::*;

  localparam int unsigned MaxW = 3;

  logic          clk = 1'b0;
  logic          rst;
  axi_slv_req_t  slv_reqs  [2];
  axi_slv_resp_t slv_resps [2];
  axi_mst_req_t  mst_req;
  axi_mst_resp_t mst_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_join_arb #(
    .SlvIdWidth (4),
    .MaxWTrans  (MaxW),
    .slv_req_t  (axi_slv_req_t),
    .slv_resp_t (axi_slv_resp_t),
    .mst_req_t  (axi_mst_req_t),
    .mst_resp_t (axi_mst_resp_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .slv_reqs_i  (slv_reqs),
    .slv_resps_o (slv_resps),
    .mst_req_o   (mst_req),
    .mst_resp_i  (mst_resp)
  );

  typedef struct {
    logic       b_valid;
    logic [4:0] b_id;
    logic       r_valid;
    logic [4:0] r_id;
    logic       r_last;
    logic [1:0] b_rdy;
    logic [1:0] r_rdy;
    logic [1:0] exp_bv;
    logic [3:0] exp_bid;
    logic       exp_mbr;
    logic [1:0] exp_rv;
    logic [3:0] exp_rid;
    logic       exp_mrr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    slv_reqs[0] = '0;
    slv_reqs[1] = '0;
    mst_resp    = '0;
  endtask

  task automatic drv_aw(input int p, input logic v, input logic [3:0] id, input logic [7:0] len);
    slv_reqs[p].aw_valid = v;
    slv_reqs[p].aw.id    = id;
    slv_reqs[p].aw.addr  = {12'h0, id};
    slv_reqs[p].aw.len   = len;
  endtask

  task automatic drv_w(input int p, input logic v, input logic [15:0] data, input logic last);
    slv_reqs[p].w_valid = v;
    slv_reqs[p].w.data  = data;
    slv_reqs[p].w.last  = last;
  endtask

  task automatic drv_ar(input int p, input logic v, input logic [3:0] id);
    slv_reqs[p].ar_valid = v;
    slv_reqs[p].ar.id    = id;
    slv_reqs[p].ar.addr  = 16'h0040;
    slv_reqs[p].ar.len   = 8'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    // random-test state
    logic [1:0] awv, wv, wlast;
    logic [3:0] awid [2];
    logic [7:0] awlen [2];
    logic [15:0] wdat [2];
    int wq [2][$];
    int wbeat [2];
    int m_fifo [$];
    int m_prio, m_lidx, idx, h;
    bit m_lock, ev, ewv, full, aw_rdy, w_rdy;

    vecs[0] = '{b_valid:1, b_id:5'h12, r_valid:1, r_id:5'h07, r_last:1, b_rdy:2'b10, r_rdy:2'b01,
                exp_bv:2'b10, exp_bid:4'h2, exp_mbr:1, exp_rv:2'b01, exp_rid:4'h7, exp_mrr:1};
    vecs[1] = '{b_valid:1, b_id:5'h05, r_valid:1, r_id:5'h1F, r_last:0, b_rdy:2'b10, r_rdy:2'b01,
                exp_bv:2'b01, exp_bid:4'h5, exp_mbr:0, exp_rv:2'b10, exp_rid:4'hF, exp_mrr:0};
    vecs[2] = '{b_valid:0, b_id:5'h1A, r_valid:0, r_id:5'h00, r_last:1, b_rdy:2'b11, r_rdy:2'b10,
                exp_bv:2'b00, exp_bid:4'hA, exp_mbr:1, exp_rv:2'b00, exp_rid:4'h0, exp_mrr:0};
    vecs[3] = '{b_valid:1, b_id:5'h10, r_valid:1, r_id:5'h13, r_last:0, b_rdy:2'b01, r_rdy:2'b10,
                exp_bv:2'b10, exp_bid:4'h0, exp_mbr:0, exp_rv:2'b10, exp_rid:4'h3, exp_mrr:1};

    // Reset state: everything gated during reset and the following cycle, B ready passes through.
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    drv_aw(0, 1, 4'h1, 8'd0);
    drv_aw(1, 1, 4'h2, 8'd0);
    mst_resp.aw_ready = 1'b1;
    mst_resp.b_valid  = 1'b1;
    mst_resp.b.id     = 5'h10;
    slv_reqs[1].b_ready = 1'b1;
    #1;
    chk("rst_mst_aw_valid", 32'(mst_req.aw_valid), 0);
    chk("rst_aw_ready0", 32'(slv_resps[0].aw_ready), 0);
    chk("rst_b_valid1", 32'(slv_resps[1].b_valid), 0);
    chk("rst_b_ready_pass", 32'(mst_req.b_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_aw_valid", 32'(mst_req.aw_valid), 0);
    chk("post_rst_aw_ready1", 32'(slv_resps[1].aw_ready), 0);
    @(negedge clk);
    clear_inputs();

    // B/R routing table.
    foreach (vecs[i]) begin
      @(negedge clk);
      mst_resp.b_valid = vecs[i].b_valid;
      mst_resp.b.id    = vecs[i].b_id;
      mst_resp.b.resp  = 2'b01;
      mst_resp.r_valid = vecs[i].r_valid;
      mst_resp.r.id    = vecs[i].r_id;
      mst_resp.r.data  = 16'hBE00 + 16'(i);
      mst_resp.r.last  = vecs[i].r_last;
      for (int p = 0; p < 2; p++) begin
        slv_reqs[p].b_ready = vecs[i].b_rdy[p];
        slv_reqs[p].r_ready = vecs[i].r_rdy[p];
      end
      #1;
      chk($sformatf("tbl%0d_b_valid", i), 32'({slv_resps[1].b_valid, slv_resps[0].b_valid}), 32'(vecs[i].exp_bv));
      chk($sformatf("tbl%0d_b_id", i), 32'(slv_resps[0].b.id), 32'(vecs[i].exp_bid));
      chk($sformatf("tbl%0d_mst_b_ready", i), 32'(mst_req.b_ready), 32'(vecs[i].exp_mbr));
      chk($sformatf("tbl%0d_r_valid", i), 32'({slv_resps[1].r_valid, slv_resps[0].r_valid}), 32'(vecs[i].exp_rv));
      chk($sformatf("tbl%0d_r_id", i), 32'(slv_resps[1].r.id), 32'(vecs[i].exp_rid));
      chk($sformatf("tbl%0d_r_last", i), 32'(slv_resps[0].r.last), 32'(vecs[i].r_last));
      chk($sformatf("tbl%0d_r_data", i), 32'(slv_resps[1].r.data), 32'h0000BE00 + 32'(i));
      chk($sformatf("tbl%0d_mst_r_ready", i), 32'(mst_req.r_ready), 32'(vecs[i].exp_mrr));
    end
    @(negedge clk);
    clear_inputs();

    // Both AW valid: port 0 then port 1; W follows grant order with a bubble after the first AW.
    @(negedge clk);
    drv_aw(0, 1, 4'h3, 8'd0);
    drv_aw(1, 1, 4'h5, 8'd0);
    drv_w(0, 1, 16'h00A0, 1);
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    #1;
    chk("t1_aw_id_a", 32'(mst_req.aw.id), 32'h03);
    chk("t1_aw_ready0", 32'(slv_resps[0].aw_ready), 1);
    chk("t1_aw_ready1_lose", 32'(slv_resps[1].aw_ready), 0);
    chk("t1_w_bubble", 32'(mst_req.w_valid), 0);
    @(negedge clk);
    drv_aw(0, 0, 4'h0, 8'd0);
    drv_w(1, 1, 16'h00B1, 1);
    #1;
    chk("t1_aw_id_b", 32'(mst_req.aw.id), 32'h15);
    chk("t1_aw_ready1", 32'(slv_resps[1].aw_ready), 1);
    chk("t1_w_data_p0", 32'(mst_req.w.data), 32'h00A0);
    chk("t1_w_ready0", 32'(slv_resps[0].w_ready), 1);
    chk("t1_w_ready1_hold", 32'(slv_resps[1].w_ready), 0);
    @(negedge clk);
    drv_aw(1, 0, 4'h0, 8'd0);
    drv_w(0, 0, 16'h0, 0);
    #1;
    chk("t1_w_data_p1", 32'(mst_req.w.data), 32'h00B1);
    chk("t1_w_ready1", 32'(slv_resps[1].w_ready), 1);
    @(negedge clk);
    drv_w(1, 0, 16'h0, 0);
    #1;
    chk("t1_w_idle", 32'(mst_req.w_valid), 0);

    // AW held while master not ready: fields stable, grant stays on port 0.
    @(negedge clk);
    drv_aw(0, 1, 4'h1, 8'd3);
    drv_aw(1, 1, 4'h2, 8'd0);
    mst_resp.aw_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("t2_aw_valid_%0d", k), 32'(mst_req.aw_valid), 1);
      chk($sformatf("t2_aw_id_%0d", k), 32'(mst_req.aw.id), 32'h01);
      chk($sformatf("t2_aw_len_%0d", k), 32'(mst_req.aw.len), 3);
      chk($sformatf("t2_aw_ready_%0d", k), 32'({slv_resps[1].aw_ready, slv_resps[0].aw_ready}), 0);
    end
    @(negedge clk);
    mst_resp.aw_ready = 1'b1;
    #1;
    chk("t2_accept_p0", 32'({slv_resps[1].aw_ready, slv_resps[0].aw_ready}), 32'b01);
    @(negedge clk);
    drv_aw(0, 0, 4'h0, 8'd0);
    #1;
    chk("t2_next_id", 32'(mst_req.aw.id), 32'h12);
    chk("t2_accept_p1", 32'(slv_resps[1].aw_ready), 1);
    @(negedge clk);
    drv_aw(1, 0, 4'h0, 8'd0);
    mst_resp.aw_ready = 1'b0;

    // W of p0 (4 beats) completes before the single beat of p1.
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      drv_w(0, logic'(k < 4), 16'h0100 + 16'(k), logic'(k == 3));
      drv_w(1, 1, 16'h0200, 1);
      #1;
      chk($sformatf("t4_w_valid_%0d", k), 32'(mst_req.w_valid), 1);
      chk($sformatf("t4_w_data_%0d", k), 32'(mst_req.w.data), (k < 4) ? 32'h0100 + 32'(k) : 32'h0200);
      chk($sformatf("t4_w_last_%0d", k), 32'(mst_req.w.last), 32'(k >= 3));
      chk($sformatf("t4_w_ready_%0d", k), 32'({slv_resps[1].w_ready, slv_resps[0].w_ready}),
          (k < 4) ? 32'b01 : 32'b10);
    end
    @(negedge clk);
    drv_w(0, 0, 16'h0, 0);
    drv_w(1, 0, 16'h0, 0);
    #1;
    chk("t4_w_done", 32'(mst_req.w_valid), 0);

    // W FIFO full: fourth AW from port 1 waits for the first W last; AR pointer moved to port 1.
    @(negedge clk);
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    drv_ar(0, 1, 4'h4);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      drv_aw(1, 1, 4'(k), 8'd0);
      #1;
      chk($sformatf("t3_aw_id_%0d", k), 32'(mst_req.aw.id), 32'h10 + 32'(k));
      chk($sformatf("t3_aw_ready_%0d", k), 32'(slv_resps[1].aw_ready), 1);
      if (k == 0) begin
        chk("t3_ar_id", 32'(mst_req.ar.id), 32'h04);
        chk("t3_ar_ready0", 32'(slv_resps[0].ar_ready), 1);
      end
      drv_ar(0, 0, 4'h0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drv_aw(1, 1, 4'h3, 8'd0);
      #1;
      chk($sformatf("t3_full_valid_%0d", k), 32'(mst_req.aw_valid), 0);
      chk($sformatf("t3_full_ready_%0d", k), 32'(slv_resps[1].aw_ready), 0);
    end
    @(negedge clk);
    drv_w(1, 1, 16'h0333, 1);
    mst_resp.w_ready = 1'b1;
    #1;
    chk("t3_full_at_pop", 32'(mst_req.aw_valid), 0);
    chk("t3_w_pop", 32'(slv_resps[1].w_ready), 1);
    @(negedge clk);
    drv_w(1, 0, 16'h0, 0);
    #1;
    chk("t3_after_pop_valid", 32'(mst_req.aw_valid), 1);
    chk("t3_after_pop_ready", 32'(slv_resps[1].aw_ready), 1);
    chk("t3_after_pop_id", 32'(mst_req.aw.id), 32'h13);

    // Reset mid-burst with three W routes queued: state dropped, pointers back to port 0.
    @(negedge clk);
    rst = 1'b1;
    drv_aw(0, 1, 4'h6, 8'd0);
    drv_aw(1, 1, 4'h7, 8'd0);
    drv_ar(0, 1, 4'h8);
    drv_ar(1, 1, 4'h9);
    drv_w(1, 1, 16'h0444, 0);
    #1;
    chk("t6_rst_aw", 32'(mst_req.aw_valid), 0);
    chk("t6_rst_ar", 32'(mst_req.ar_valid), 0);
    chk("t6_rst_w", 32'(mst_req.w_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_post_valids", 32'({mst_req.aw_valid, mst_req.ar_valid, mst_req.w_valid}), 0);
    chk("t6_post_w_ready", 32'(slv_resps[1].w_ready), 0);
    @(negedge clk);
    mst_resp.aw_ready = 1'b0;
    mst_resp.ar_ready = 1'b0;
    #1;
    chk("t6_fifo_empty", 32'(mst_req.w_valid), 0);
    chk("t6_aw_ptr0", 32'(mst_req.aw.id), 32'h06);
    chk("t6_ar_ptr0", 32'(mst_req.ar.id), 32'h08);
    chk("t6_ar_valid", 32'(mst_req.ar_valid), 1);

    // Randomized AW/W traffic against a queue-based model.
    do_reset();
    awv = '0; wv = '0; wlast = '0;
    wbeat[0] = 0; wbeat[1] = 0;
    m_prio = 0; m_lock = 0; m_lidx = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!awv[p] && $urandom_range(2) == 0) begin
          awv[p] = 1'b1;
          awid[p] = 4'($urandom);
          awlen[p] = 8'($urandom_range(3));
        end
        if (!wv[p] && wq[p].size() > 0 && $urandom_range(1) == 0) begin
          wv[p] = 1'b1;
          wdat[p] = 16'($urandom);
          wlast[p] = (wbeat[p] == wq[p][0] - 1);
        end
        drv_aw(p, awv[p], awid[p], awlen[p]);
        drv_w(p, wv[p], wdat[p], wlast[p]);
      end
      aw_rdy = ($urandom_range(3) != 0);
      w_rdy  = ($urandom_range(3) != 0);
      mst_resp.aw_ready = aw_rdy;
      mst_resp.w_ready  = w_rdy;
      #1;
      full = (m_fifo.size() >= MaxW);
      ev = 0;
      idx = m_prio;
      if (m_lock) begin
        idx = m_lidx;
        ev = awv[idx] && !full;
      end else if (!full) begin
        for (int k = 0; k < 2; k++) begin
          if (!ev && awv[(m_prio + k) % 2]) begin
            idx = (m_prio + k) % 2;
            ev = 1;
          end
        end
      end
      h = (m_fifo.size() > 0) ? m_fifo[0] : 0;
      ewv = (m_fifo.size() > 0) && wv[h];
      chk("rnd_aw_valid", 32'(mst_req.aw_valid), 32'(ev));
      if (ev) begin
        chk("rnd_aw_id", 32'(mst_req.aw.id), 32'(idx * 16 + int'(awid[idx])));
        chk("rnd_aw_len", 32'(mst_req.aw.len), 32'(awlen[idx]));
      end
      for (int p = 0; p < 2; p++) begin
        chk("rnd_aw_ready", 32'(slv_resps[p].aw_ready), 32'(ev && idx == p && aw_rdy));
        chk("rnd_w_ready", 32'(slv_resps[p].w_ready), 32'(m_fifo.size() > 0 && h == p && w_rdy));
      end
      chk("rnd_w_valid", 32'(mst_req.w_valid), 32'(ewv));
      if (ewv) begin
        chk("rnd_w_data", 32'(mst_req.w.data), 32'(wdat[h]));
        chk("rnd_w_last", 32'(mst_req.w.last), 32'(wlast[h]));
      end
      // advance model and stimulus for the coming edge
      if (ev && aw_rdy) begin
        m_fifo.push_back(idx);
        m_prio = 1 - idx;
        awv[idx] = 1'b0;
        wq[idx].push_back(int'(awlen[idx]) + 1);
      end
      m_lock = ev && !aw_rdy;
      m_lidx = idx;
      if (ewv && w_rdy) begin
        wv[h] = 1'b0;
        wbeat[h]++;
        if (wlast[h]) begin
          void'(m_fifo.pop_front());
          void'(wq[h].pop_front());
          wbeat[h] = 0;
        end
      end
    end

    @(negedge clk);
    clear_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
